// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory access controller: access sizes, FSM states
// and small decode helpers.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCESS    = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    // Encoding 2'b11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        if (size == SZ_HALF) begin
            bad = lsb[0];
        end else if (is_word(size)) begin
            bad = (lsb != 2'b00);
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Big-endian lane formatting: load extraction/extension and sub-word store
// merge against the word read back from memory.
module mem_lane_fmt
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_do,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    // The addressed byte sits in the top lane of mem_do.
    always_comb begin
        load_data = mem_do;
        merged    = mem_do;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sext & mem_do[31]}}, mem_do[31:24]};
                merged    = {wdata[7:0], mem_do[23:0]};
            end
            SZ_HALF: begin
                load_data = {{16{sext & mem_do[31]}}, mem_do[31:16]};
                merged    = {wdata[15:0], mem_do[15:0]};
            end
            default: begin
                load_data = mem_do;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side memory access controller with read-modify-write for sub-word stores.
// Optional misalignment trap is enabled by defining MEMCTL_MISALIGN_TRAP_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_di,
    output logic              mem_wr,
    input  logic [31:0]       mem_do
);

    state_t             state;
    logic               ready_r;
    logic               done_r;
    logic               mem_wr_r;
    logic [31:0]        rdata_r;
    logic [31:0]        mem_di_r;
    logic [31:0]        wdata_r;
    logic [ADDR_W-1:0]  addr_r;
    logic               we_r;
    logic               sext_r;
    logic [1:0]         size_r;
    logic [31:0]        load_data;
    logic [31:0]        merged;
`ifdef MEMCTL_MISALIGN_TRAP_EN
    logic               err_r;
`endif

    mem_lane_fmt u_lane_fmt (
        .size      (size_r),
        .sext      (sext_r),
        .wdata     (wdata_r),
        .mem_do    (mem_do),
        .load_data (load_data),
        .merged    (merged)
    );

    // Access sequencer; every output it drives is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            mem_wr_r <= 1'b0;
            rdata_r  <= 32'd0;
`ifdef MEMCTL_MISALIGN_TRAP_EN
            err_r    <= 1'b0;
`endif
        end else begin
            done_r   <= 1'b0;
            mem_wr_r <= 1'b0;
`ifdef MEMCTL_MISALIGN_TRAP_EN
            err_r    <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    ready_r <= 1'b1;
                    if (req) begin
                        addr_r   <= addr;
                        we_r     <= we;
                        size_r   <= size;
                        sext_r   <= sext;
                        wdata_r  <= wdata;
                        mem_di_r <= wdata;
                        ready_r  <= 1'b0;
`ifdef MEMCTL_MISALIGN_TRAP_EN
                        if (misaligned(size, addr[1:0])) begin
                            state  <= ST_RESP;
                            done_r <= 1'b1;
                            err_r  <= 1'b1;
                        end else begin
                            state    <= ST_ACCESS;
                            mem_wr_r <= we & is_word(size);
                        end
`else
                        state    <= ST_ACCESS;
                        mem_wr_r <= we & is_word(size);
`endif
                    end
                end
                ST_ACCESS: begin
                    if (we_r && is_word(size_r)) begin
                        state  <= ST_RESP;
                        done_r <= 1'b1;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                // mem_do now reflects the word addressed during ACCESS.
                ST_CAPTURE: begin
                    if (we_r) begin
                        mem_di_r <= merged;
                        mem_wr_r <= 1'b1;
                        state    <= ST_WRITEBACK;
                    end else begin
                        rdata_r <= load_data;
                        done_r  <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                ST_WRITEBACK: begin
                    state  <= ST_RESP;
                    done_r <= 1'b1;
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Reset suppresses side effects within the very cycle it is asserted.
    assign mem_wr = mem_wr_r & ~rst;
    assign done   = done_r & ~rst;
`ifdef MEMCTL_MISALIGN_TRAP_EN
    assign err    = err_r & ~rst;
`else
    assign err    = 1'b0;
`endif
    assign ready  = ready_r;
    assign rdata  = rdata_r;
    assign mem_a  = addr_r;
    assign mem_di = mem_di_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl with a big-endian byte memory
// model; expectations adapt to MEMCTL_MISALIGN_TRAP_EN.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [11:0] mem_a;
    logic [31:0] mem_di;
    logic        mem_wr;
    logic [31:0] mem_do;

    logic [7:0]  mem [0:4095];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;
    int          wr_count;
    logic [31:0] last_wdata;

    int n_chk;
    int n_pass;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          nwr;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];
    int   dq[$];

    mem_access_ctrl #(.ADDR_W(12)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .size   (size),
        .sext   (sext),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .done   (done),
        .rdata  (rdata),
        .err    (err),
        .mem_a  (mem_a),
        .mem_di (mem_di),
        .mem_wr (mem_wr),
        .mem_do (mem_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read big-endian memory with a bench preload port.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr]         <= pl_data[31:24];
            mem[pl_addr + 12'd1] <= pl_data[23:16];
            mem[pl_addr + 12'd2] <= pl_data[15:8];
            mem[pl_addr + 12'd3] <= pl_data[7:0];
        end else if (mem_wr) begin
            wr_count             <= wr_count + 1;
            last_wdata           <= mem_di;
            mem[mem_a]           <= mem_di[31:24];
            mem[mem_a + 12'd1]   <= mem_di[23:16];
            mem[mem_a + 12'd2]   <= mem_di[15:8];
            mem[mem_a + 12'd3]   <= mem_di[7:0];
        end
        mem_do <= {mem[mem_a], mem[mem_a + 12'd1], mem[mem_a + 12'd2], mem[mem_a + 12'd3]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [11:0] a, input logic [31:0] wd,
                          input logic [31:0] e_rd, input logic e_er, input int e_lat,
                          input int e_nwr, input logic [31:0] e_wd);
        exp_t e;
        exp_t x;
        int   n;
        int   wr0;
        e.rd = e_rd; e.er = e_er; e.lat = e_lat; e.nwr = e_nwr; e.wd = e_wd;
        @(negedge clk);
        check("ready_before", {31'd0, ready}, 32'd1);
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
        sb.push_back(e);
        wr0 = wr_count;
        @(negedge clk);
        req = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        x = sb.pop_front();
        check("latency", n, x.lat);
        check("rdata", rdata, x.rd);
        check("err", {31'd0, err}, {31'd0, x.er});
        check("write_count", wr_count - wr0, x.nwr);
        if (x.nwr > 0) check("write_data", last_wdata, x.wd);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("ready_after", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int wr0;
        n_chk = 0; n_pass = 0; wr_count = 0; last_wdata = 32'd0;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        addr = 12'd0; wdata = 32'd0; pl_en = 1'b0; pl_addr = 12'd0; pl_data = 32'd0;

        preload(12'h003, 32'h112280AA);
        preload(12'h005, 32'h80AABBCC);
        preload(12'h010, 32'h11223344);
        preload(12'h020, 32'h00000000);
        preload(12'h030, 32'h01020304);
        preload(12'h040, 32'h9ABC1357);
        preload(12'h050, 32'hCAFEF00D);

        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        rst = 1'b0;

        access(1'b0, 2'b00, 1'b1, 12'h005, 32'd0, 32'hFFFFFF80, 1'b0, 3, 0, 32'd0);
        access(1'b0, 2'b00, 1'b0, 12'h005, 32'd0, 32'h00000080, 1'b0, 3, 0, 32'd0);
        access(1'b0, 2'b01, 1'b1, 12'h040, 32'd0, 32'hFFFF9ABC, 1'b0, 3, 0, 32'd0);
        access(1'b0, 2'b01, 1'b0, 12'h040, 32'd0, 32'h00009ABC, 1'b0, 3, 0, 32'd0);
        access(1'b1, 2'b01, 1'b0, 12'h010, 32'h1234BEEF, 32'h00009ABC, 1'b0, 4, 1, 32'hBEEF3344);
        access(1'b0, 2'b10, 1'b0, 12'h010, 32'd0, 32'hBEEF3344, 1'b0, 3, 0, 32'd0);
        access(1'b1, 2'b00, 1'b0, 12'h030, 32'h000000A5, 32'hBEEF3344, 1'b0, 4, 1, 32'hA5020304);
        access(1'b0, 2'b10, 1'b0, 12'h030, 32'd0, 32'hA5020304, 1'b0, 3, 0, 32'd0);
        access(1'b1, 2'b10, 1'b0, 12'h020, 32'hDEADBEEF, 32'hA5020304, 1'b0, 2, 1, 32'hDEADBEEF);
        access(1'b0, 2'b11, 1'b0, 12'h020, 32'd0, 32'hDEADBEEF, 1'b0, 3, 0, 32'd0);
`ifdef MEMCTL_MISALIGN_TRAP_EN
        access(1'b0, 2'b10, 1'b0, 12'h003, 32'd0, 32'hDEADBEEF, 1'b1, 1, 0, 32'd0);
        access(1'b0, 2'b01, 1'b1, 12'h005, 32'd0, 32'hDEADBEEF, 1'b1, 1, 0, 32'd0);
`else
        access(1'b0, 2'b10, 1'b0, 12'h003, 32'd0, 32'h112280AA, 1'b0, 3, 0, 32'd0);
        access(1'b0, 2'b01, 1'b1, 12'h005, 32'd0, 32'hFFFF80AA, 1'b0, 3, 0, 32'd0);
`endif

        // Reset lands while the byte store is in WRITEBACK.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; addr = 12'h050; wdata = 32'h00000077;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wb_mem_wr_before_rst", {31'd0, mem_wr}, 32'd1);
        wr0 = wr_count;
        rst = 1'b1;
        #1;
        check("wb_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("wb_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("wb_rst_ready", {31'd0, ready}, 32'd1);
        check("wb_rst_done_next", {31'd0, done}, 32'd0);
        check("wb_rst_rdata", rdata, 32'd0);
        check("wb_rst_no_write", wr_count - wr0, 32'd0);
        rst = 1'b0;
        access(1'b0, 2'b10, 1'b0, 12'h050, 32'd0, 32'hCAFEF00D, 1'b0, 3, 0, 32'd0);

        // req held high: loads accepted only in IDLE, one completion every 4 cycles.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 12'h020;
        dq.push_back(3); dq.push_back(7); dq.push_back(11);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("b2b_ready", {31'd0, ready}, {31'd0, (k % 4) == 0});
            check("b2b_done", {31'd0, done}, {31'd0, (k % 4) == 3});
            if (done === 1'b1) begin
                if (dq.size() > 0) check("b2b_done_cycle", k, dq.pop_front());
                else check("b2b_unexpected_done", k, 32'd0);
                check("b2b_rdata", rdata, 32'hDEADBEEF);
            end
            if (k == 12) req = 1'b0;
        end
        check("b2b_all_done", dq.size(), 32'd0);
        @(negedge clk);
        check("b2b_idle", {31'd0, ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning byte-address width shared with the banked memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 1, CPU access request, sampled only while ready=1.
REQ-005 SHALL have port we, input, 1, 1=store, 0=load.
REQ-006 SHALL have port size, input, 2, 00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-007 SHALL have port sext, input, 1, sign-extend sub-word loads when 1, zero-extend when 0.
REQ-008 SHALL have port addr, input, ADDR_W, byte address.
REQ-009 SHALL have port wdata, input, 32, store data, right-aligned for sub-word sizes.
REQ-010 SHALL have port ready, output, 1, high only in IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port rdata, output, 32, extended load result, held until the next accepted load.
REQ-013 SHALL have port err, output, 1, misalignment flag (see Configuration); constant 0 when the feature is compiled out.
REQ-014 SHALL have port mem_a, output, ADDR_W, memory byte address.
REQ-015 SHALL have port mem_di, output, 32, memory write data.
REQ-016 SHALL have port mem_wr, output, 1, memory write enable.
REQ-017 SHALL have port mem_do, input, 32, memory read data, big-endian: [31:24] holds the byte at mem_a, [7:0] holds the byte at mem_a+3; valid the cycle after mem_a is presented.

Function
REQ-018 SHALL capture addr/we/size/sext/wdata into internal registers on the edge where req=1 and ready=1.
REQ-019 SHALL implement states IDLE, ACCESS, CAPTURE, WRITEBACK, RESP.
REQ-020 Load: IDLE->ACCESS (mem_a=addr, mem_wr=0)->CAPTURE (register rdata)->RESP (done=1)->IDLE; done SHALL occur 3 cycles after acceptance.
REQ-021 Word store: IDLE->ACCESS (mem_a=addr, mem_di=wdata, mem_wr=1)->RESP->IDLE; done 2 cycles after acceptance.
REQ-022 Sub-word store: ACCESS (read)->CAPTURE (merge)->WRITEBACK (mem_wr=1, mem_di=merged)->RESP; done 4 cycles after acceptance.
REQ-023 Merge: byte replaces mem_do[31:24] with wdata[7:0]; halfword replaces mem_do[31:16] with wdata[15:0]; remaining bytes are preserved.
REQ-024 Load extraction: byte = mem_do[31:24], halfword = mem_do[31:16], word = mem_do; extended to 32 bits per sext.
REQ-025 mem_wr SHALL be high only in ACCESS (word store) or WRITEBACK and SHALL be gated by ~rst.
REQ-026 mem_a SHALL hold the latched address in every non-IDLE state; it is don't-care in IDLE.
REQ-027 Addresses SHALL wrap modulo 2^ADDR_W; no boundary check is performed.
REQ-028 req SHALL be ignored while ready=0; a new request may be accepted in the cycle after RESP.

Reset
REQ-029 On rst=1, the state SHALL go to IDLE, with ready=1, done=0, err=0, rdata=0, and mem_wr=0 in that same cycle (combinational gate).
REQ-030 Reset mid-operation SHALL abandon the access: no write commits, no done pulse.

Configuration
REQ-031 With MEMCTL_MISALIGN_TRAP_EN defined, a halfword request with addr[0]=1, or a word request with addr[1:0]!=0, SHALL skip memory and go IDLE->RESP with done=1 and err=1 for that cycle, leaving rdata and memory unchanged.
REQ-032 Without MEMCTL_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed normally, since the memory supports them, and err is tied to 0.

Structure
REQ-033 A shared package mem_ctrl_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-034 A combinational sub-module mem_lane_fmt SHALL perform load extraction/extension and store merge.

Verification
REQ-035 Load byte, sext=1, addr=0x005, mem_do=0x80AABBCC -> rdata=0xFFFFFF80, done 3 cycles after accept.
REQ-036 Store half, addr=0x010, wdata=0x1234BEEF, read 0x11223344 -> single write of mem_di=0xBEEF3344 in WRITEBACK, done at cycle 4.
REQ-037 Store word, addr=0x020, wdata=0xDEADBEEF -> mem_wr=1 for exactly one cycle, done at cycle 2.
REQ-038 Word load at addr=0x003: with the macro, done=1 and err=1 one cycle after accept with no mem_wr; without it, rdata=mem_do.
REQ-039 rst asserted during WRITEBACK -> mem_wr=0 that cycle, no done, ready=1 next cycle.
REQ-040 req held high continuously -> requests are accepted only in IDLE, and back-to-back loads complete every 4 cycles.
